user_write_arbiter: RTL and testbench

USER_WRITE_ARBITER -- requirements
Module: user_write_arbiter

---
 rtl/user_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/user_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_user_write_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/user_arb_pkg.sv
// Shared constants and per-user state encoding for the user write arbiter.
package user_arb_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned N_USERS_DEF     = 4;
    localparam int unsigned AUTH_ID_DEF     = 2;
    localparam int unsigned LOCK_THRESH_DEF = 3;
    localparam int unsigned BLOCK_CYC_DEF   = 16;
    localparam int unsigned USR_ID_W        = 2;
    localparam int unsigned VIOL_W          = 8;

    typedef logic [0:0] usr_state_t;
    localparam usr_state_t ST_OPEN    = 1'b0;
    localparam usr_state_t ST_BLOCKED = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority one-hot search starting just after last_grant.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req_mask,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant_c,
    output logic [ID_W-1:0] grant_id_c,
    output logic            grant_any_c
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_c     = '0;
        grant_id_c  = '0;
        grant_any_c = 1'b0;
        idx         = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = ID_W'((32'(last_grant) + off) % N);
            if (!grant_any_c && req_mask[idx]) begin
                grant_c[idx] = 1'b1;
                grant_id_c   = idx;
                grant_any_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/user_write_arbiter.sv
// Round-robin write arbiter in front of a locked register; blocks users that
// repeatedly write without authorization and counts violations.
module user_write_arbiter
    import user_arb_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned N_USERS     = N_USERS_DEF,
    parameter int unsigned AUTH_ID     = AUTH_ID_DEF,
    parameter int unsigned LOCK_THRESH = LOCK_THRESH_DEF,
    parameter int unsigned BLOCK_CYC   = BLOCK_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_USERS-1:0]        req_valid,
    input  logic [N_USERS*DATA_W-1:0] req_data,
    output logic [N_USERS-1:0]        req_ready,
    output logic [USR_ID_W-1:0]       out_usr_id,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      viol_clr,
    output logic [VIOL_W-1:0]         viol_count,
    output logic                      viol_flag
);

    localparam int unsigned VC_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned BC_W = $clog2(BLOCK_CYC + 1);

    logic [N_USERS-1:0]  blocked;
    logic [N_USERS-1:0]  req_mask_c;
    logic [N_USERS-1:0]  grant_c;
    logic [USR_ID_W-1:0] grant_id_c;
    logic                grant_any_c;
    logic [USR_ID_W-1:0] last_grant;
    logic [DATA_W-1:0]   sel_data_c;
    logic                viol_c;

    assign req_mask_c = req_valid & ~blocked;
    assign req_ready  = grant_c;
    assign viol_c     = grant_any_c && (grant_id_c != USR_ID_W'(AUTH_ID));

    rr_arbiter #(
        .N    (N_USERS),
        .ID_W (USR_ID_W)
    ) u_rr (
        .req_mask    (req_mask_c),
        .last_grant  (last_grant),
        .grant_c     (grant_c),
        .grant_id_c  (grant_id_c),
        .grant_any_c (grant_any_c)
    );

    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < N_USERS; i++) begin
            if (grant_c[i]) sel_data_c = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Forwarded write: ID drops to 0 when idle so AUTH_ID is never presented spuriously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= USR_ID_W'(N_USERS - 1);
            out_valid  <= 1'b0;
            out_usr_id <= '0;
            out_data   <= '0;
        end else begin
            out_valid  <= grant_any_c;
            out_usr_id <= grant_any_c ? grant_id_c : '0;
            if (grant_any_c) begin
                last_grant <= grant_id_c;
                out_data   <= sel_data_c;
            end
        end
    end

    // Violation statistics; clear has priority over a same-cycle violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_count <= '0;
            viol_flag  <= 1'b0;
        end else if (viol_clr) begin
            viol_count <= '0;
            viol_flag  <= 1'b0;
        end else if (viol_c) begin
            viol_flag <= 1'b1;
            if (viol_count != '1) viol_count <= viol_count + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_USERS; gi++) begin : g_user
        localparam bit IS_AUTH = (32'(gi) == AUTH_ID);

        usr_state_t      st_q, st_d;
        logic [VC_W-1:0] vc_q, vc_d;
        logic [BC_W-1:0] bc_q, bc_d;
        logic            hit_c;

        assign hit_c        = grant_c[gi] & ~IS_AUTH;
        assign blocked[gi]  = (st_q == ST_BLOCKED);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= ST_OPEN;
                vc_q <= '0;
                bc_q <= '0;
            end else begin
                st_q <= st_d;
                vc_q <= vc_d;
                bc_q <= bc_d;
            end
        end

        always_comb begin
            st_d = st_q;
            vc_d = vc_q;
            bc_d = bc_q;
            case (st_q)
                ST_OPEN: begin
                    if (hit_c) begin
                        if (vc_q == VC_W'(LOCK_THRESH - 1)) begin
                            st_d = ST_BLOCKED;
                            vc_d = '0;
                            bc_d = BC_W'(BLOCK_CYC);
                        end else begin
                            vc_d = vc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bc_q == BC_W'(1)) begin
                        st_d = ST_OPEN;
                        bc_d = '0;
                    end else begin
                        bc_d = bc_q - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_write_arbiter.sv
// Randomized and directed checks of user_write_arbiter against a cycle-level behavioural model.
module tb_user_write_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AUTH = 2;
    localparam int THR  = 3;
    localparam int BLK  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [1:0]    out_usr_id;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          viol_clr;
    logic [7:0]    viol_count;
    logic          viol_flag;

    user_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_usr_id (out_usr_id),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .viol_clr   (viol_clr),
        .viol_count (viol_count),
        .viol_flag  (viol_flag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Model state: blocked-cycles-remaining per user, violations per user, statistics, expected outputs.
    int m_last;
    int m_blk[N];
    int m_vc[N];
    int m_count;
    int m_flag;
    int m_ov;
    int m_id;
    int m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_last = N - 1;
        for (int u = 0; u < N; u++) begin
            m_blk[u] = 0;
            m_vc[u]  = 0;
        end
        m_count = 0;
        m_flag  = 0;
        m_ov    = 0;
        m_id    = 0;
        m_data  = 0;
    endtask

    function automatic int pred_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int u;
            u = (m_last + k) % N;
            if (v[u] && m_blk[u] == 0) return u;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, compare just after, then advance the model past the posedge.
    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit clr, output int g);
        bit viol;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        viol_clr  = clr;
        #1;
        g = pred_grant(v);
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_usr_id", 32'(out_usr_id), 32'(m_id));
        check("out_data", 32'(out_data), 32'(m_data));
        check("viol_count", 32'(viol_count), 32'(m_count));
        check("viol_flag", 32'(viol_flag), 32'(m_flag));
        for (int u = 0; u < N; u++) begin
            if (m_blk[u] > 0) m_blk[u]--;
            else if (u == g && u != AUTH) begin
                m_vc[u]++;
                if (m_vc[u] == THR) begin
                    m_vc[u]  = 0;
                    m_blk[u] = BLK;
                end
            end
        end
        viol = (g >= 0) && (g != AUTH);
        if (g >= 0) begin
            m_last = g;
            m_ov   = 1;
            m_id   = g;
            m_data = int'((d >> (DW * g)) & 32'hFF);
        end else begin
            m_ov = 0;
            m_id = 0;
        end
        if (clr) begin
            m_count = 0;
            m_flag  = 0;
        end else if (viol) begin
            if (m_count < 255) m_count++;
            m_flag = 1;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_id"}, 32'(out_usr_id), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_cnt"}, 32'(viol_count), 32'd0);
        check({tag, "_flag"}, 32'(viol_flag), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        viol_clr  = 1'b0;
        reset_model();
        @(negedge clk);
        #1;
        check_reset_outs("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        logic [N-1:0]    pv;
        logic [N*DW-1:0] pd;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        viol_clr  = 1'b0;
        reset_model();
        do_reset();

        // Round-robin order from reset with everyone requesting.
        for (int k = 0; k < N; k++) begin
            step(4'b1111, 32'h44332211, 1'b0, g);
            check("rr_ready", 32'(req_ready), 32'd1 << k);
        end
        step(4'b0000, 32'h0, 1'b0, g);
        check("rr_last_id", 32'(out_usr_id), 32'd3);

        // Authorized write passes without a violation.
        do_reset();
        step(4'b0100, 32'h00A50000, 1'b0, g);
        check("auth_ready", 32'(req_ready), 32'b0100);
        step(4'b0000, 32'h0, 1'b0, g);
        check("auth_ov", 32'(out_valid), 32'd1);
        check("auth_id", 32'(out_usr_id), 32'd2);
        check("auth_data", 32'(out_data), 32'hA5);
        check("auth_cnt", 32'(viol_count), 32'd0);

        // Three unauthorized grants block user 1 for exactly BLK cycles.
        do_reset();
        for (int k = 0; k < THR; k++) step(4'b0010, 32'h00001100, 1'b0, g);
        for (int k = 0; k < BLK; k++) begin
            step(4'b0010, 32'h00001100, 1'b0, g);
            check("blk_ready", 32'(req_ready), 32'd0);
        end
        check("blk_cnt", 32'(viol_count), 32'd3);
        check("blk_flag", 32'(viol_flag), 32'd1);
        step(4'b0010, 32'h00001100, 1'b0, g);
        check("unblk_ready", 32'(req_ready), 32'b0010);

        // Saturation at 255, then clear beating a simultaneous violation.
        do_reset();
        for (int k = 0; k < 3000 && m_count < 255; k++) step(4'b1111, 32'h44332211, 1'b0, g);
        for (int k = 0; k < 6; k++) step(4'b1011, 32'h44332211, 1'b0, g);
        check("sat_cnt", 32'(viol_count), 32'd255);
        for (int k = 0; k < 40 && pred_grant(4'b1011) < 0; k++) step(4'b0000, 32'h0, 1'b0, g);
        step(4'b1011, 32'h44332211, 1'b1, g);
        check("clr_viol_grant", 32'(g >= 0 && g != AUTH), 32'd1);
        step(4'b0000, 32'h0, 1'b0, g);
        check("clr_cnt", 32'(viol_count), 32'd0);
        check("clr_flag", 32'(viol_flag), 32'd0);

        // Reset while user 3 is blocked and a grant to user 0 is pending.
        do_reset();
        for (int k = 0; k < THR; k++) step(4'b1000, 32'h77000000, 1'b0, g);
        @(negedge clk);
        req_valid = 4'b1001;
        req_data  = 32'h77000011;
        #1;
        check("pend_ready", 32'(req_ready), 32'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid");
        reset_model();
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        step(4'b1000, 32'h77000000, 1'b0, g);
        check("rel_ready", 32'(req_ready), 32'b1000);
        step(4'b0000, 32'h0, 1'b0, g);
        check("rel_id", 32'(out_usr_id), 32'd3);

        // Random traffic honouring hold-until-granted.
        do_reset();
        pv = '0;
        pd = '0;
        for (int k = 0; k < 600; k++) begin
            for (int u = 0; u < N; u++) begin
                if (!pv[u] && $urandom_range(0, 1) == 1) begin
                    pv[u]          = 1'b1;
                    pd[DW*u +: DW] = DW'($urandom);
                end
            end
            step(pv, pd, $urandom_range(0, 15) == 0, g);
            if (g >= 0) pv[g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
